bus_arbiter8: RTL and testbench

Round-robin arbiter that shares one 16-bit Hack data bus among 8 requesters. It uses the existing mux8way16_gate for data steering and dmux8way_gate for one-hot grant decode. The FSM adds the sequencing those combinational gates lack: grant, hold, release and rotation. It is the first sequential consumer of the Project 1 gate library and feeds the memory/IO bus.

---
 rtl/hack_arb_pkg.sv | 11 +
 rtl/dmux8way_gate.sv | 22 ++
 rtl/mux8way16_gate.sv | 19 +
 rtl/rr_pick8.sv | 25 ++
 rtl/bus_arbiter8.sv | 95 +++++++++
 tb/tb_bus_arbiter8.sv | 235 +++++++++++++++++++++++
 6 files changed

// File: rtl/hack_arb_pkg.sv
// Shared constants and FSM state encoding for the Hack bus arbiter.
package hack_arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int WORD_W  = 16;
  localparam int ID_W    = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/dmux8way_gate.sv
// Project 1 gate library: 1-to-8 demultiplexer.
module dmux8way_gate (
  input  logic       in,
  input  logic [2:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h
);
  assign a = in & ~sel[2] & ~sel[1] & ~sel[0];
  assign b = in & ~sel[2] & ~sel[1] &  sel[0];
  assign c = in & ~sel[2] &  sel[1] & ~sel[0];
  assign d = in & ~sel[2] &  sel[1] &  sel[0];
  assign e = in &  sel[2] & ~sel[1] & ~sel[0];
  assign f = in &  sel[2] & ~sel[1] &  sel[0];
  assign g = in &  sel[2] &  sel[1] & ~sel[0];
  assign h = in &  sel[2] &  sel[1] &  sel[0];
endmodule

// File: rtl/mux8way16_gate.sv
// Project 1 gate library: 16-bit, 8-way multiplexer.
module mux8way16_gate (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  input  logic [2:0]  sel,
  output logic [15:0] out
);
  logic [15:0] lo, hi;

  assign lo  = sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);
  assign hi  = sel[1] ? (sel[0] ? h : g) : (sel[0] ? f : e);
  assign out = sel[2] ? hi : lo;
endmodule

// File: rtl/rr_pick8.sv
// Rotating-priority picker: first set request scanning ptr, ptr+1, ... mod 8.
module rr_pick8
  import hack_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);
  logic [ID_W-1:0] cand;

  // Scan from the far end so the candidate closest to ptr is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + ID_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter sharing one 16-bit Hack bus among 8 requesters,
// with bounded hold and a mandatory idle turnaround between grants.
module bus_arbiter8
  import hack_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ID_W-1:0]           gnt_id,
  output logic                      bus_valid,
  output logic [WORD_W-1:0]         bus_data,
  output logic                      busy
);
  localparam logic [3:0] LAST_BEAT = 4'(MAX_HOLD - 1);

  state_t            state;
  logic [ID_W-1:0]   ptr;
  logic [3:0]        beats;
  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic              held, last_beat, rel, start, busy_nxt;
  logic [ID_W-1:0]   gnt_id_nxt;
  logic [NUM_REQ-1:0] gnt_dec;
  logic [WORD_W-1:0] mux_out;

  rr_pick8 u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign busy      = (state == ST_GRANT);
  assign held      = req[gnt_id];
  assign bus_valid = busy & held;
  assign last_beat = bus_valid && (beats == LAST_BEAT);
  assign rel       = busy && (!held || last_beat);
  // Only IDLE may start a grant, which enforces the turnaround cycle.
  assign start     = !busy && en && pick_found;
  assign busy_nxt  = start || (busy && !rel);
  assign gnt_id_nxt = start ? pick_idx : (busy_nxt ? gnt_id : '0);

  dmux8way_gate u_dec (
    .in  (busy_nxt),
    .sel (gnt_id_nxt),
    .a   (gnt_dec[0]),
    .b   (gnt_dec[1]),
    .c   (gnt_dec[2]),
    .d   (gnt_dec[3]),
    .e   (gnt_dec[4]),
    .f   (gnt_dec[5]),
    .g   (gnt_dec[6]),
    .h   (gnt_dec[7])
  );

  mux8way16_gate u_mux (
    .a   (req_data[0*WORD_W +: WORD_W]),
    .b   (req_data[1*WORD_W +: WORD_W]),
    .c   (req_data[2*WORD_W +: WORD_W]),
    .d   (req_data[3*WORD_W +: WORD_W]),
    .e   (req_data[4*WORD_W +: WORD_W]),
    .f   (req_data[5*WORD_W +: WORD_W]),
    .g   (req_data[6*WORD_W +: WORD_W]),
    .h   (req_data[7*WORD_W +: WORD_W]),
    .sel (gnt_id),
    .out (mux_out)
  );

  assign bus_data = mux_out & {WORD_W{bus_valid}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      ptr    <= '0;
      beats  <= '0;
    end else begin
      state  <= busy_nxt ? ST_GRANT : ST_IDLE;
      gnt    <= gnt_dec;
      gnt_id <= gnt_id_nxt;
      if (start || rel)
        beats <= '0;
      else if (bus_valid)
        beats <= beats + 4'd1;
      if (rel)
        ptr <= gnt_id + 3'd1;
    end
  end
endmodule

// File: tb/tb_bus_arbiter8.sv
// Self-checking bench for bus_arbiter8: per-cycle reference model plus directed scenarios.
module tb_bus_arbiter8;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [7:0]   req = 8'h00;
  logic [127:0] req_data;
  logic [7:0]   gnt;
  logic [2:0]   gnt_id;
  logic         bus_valid;
  logic [15:0]  bus_data;
  logic         busy;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Reference model state (plain integers, one grant at a time)
  int m_busy = 0, m_id = 0, m_ptr = 0, m_beats = 0;
  int glog[$];
  int dlog[$];

  bus_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: advance on each rising edge, reset immediately on rst_n fall.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_id = 0; m_ptr = 0; m_beats = 0;
    end else if (m_busy == 0) begin
      if (en && req != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          int c;
          c = (m_ptr + k) % 8;
          if (m_busy == 0 && req[c]) begin
            m_busy = 1; m_id = c; m_beats = 0;
            glog.push_back(c);
          end
        end
      end
    end else begin
      if (req[m_id] && m_beats < MAX_HOLD - 1)
        m_beats++;
      else begin
        m_busy = 0; m_ptr = (m_id + 1) % 8; m_id = 0; m_beats = 0;
      end
    end
  end

  // Compare DUT outputs against the model mid-cycle.
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      logic        e_valid;
      logic [15:0] e_data;
      e_valid = (m_busy != 0) && req[m_id];
      e_data  = e_valid ? req_data[m_id*16 +: 16] : 16'h0000;
      check("m_gnt", gnt, m_busy != 0 ? (32'd1 << m_id) : 32'd0);
      check("m_gnt_id", gnt_id, m_busy != 0 ? m_id : 0);
      check("m_busy", busy, m_busy);
      check("m_valid", bus_valid, e_valid);
      check("m_data", bus_data, e_data);
    end
  end

  initial begin
    int vc;
    bit pb;
    bit exp_v[6];

    for (int k = 0; k < 8; k++) req_data[k*16 +: 16] = 16'hA000 + 16'(k * 16'h0111);
    req_data[2*16 +: 16] = 16'hBEEF;

    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", bus_valid, 0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    en = 1'b1;
    step(1);

    // Single beat on requester 2, release moves ptr to 3
    req = 8'h04;
    step(1);
    check("t2_gnt", gnt, 8'h04);
    check("t2_gnt_id", gnt_id, 2);
    check("t2_valid", bus_valid, 1);
    check("t2_data", bus_data, 16'hBEEF);
    step(1);
    req = 8'h00;
    #1;
    check("t2_nobeat", bus_valid, 0);
    check("t2_nodata", bus_data, 0);
    step(1);
    check("t2_rel_busy", busy, 0);
    check("t2_rel_gnt", gnt, 0);
    req = 8'h09;
    step(1);
    check("t2_ptr3", gnt_id, 3);
    req = 8'h00;
    step(1);

    // Reset in the second beat of a grant to 0; ptr returns to 0
    req = 8'h01;
    step(1);
    check("t1_gnt_id", gnt_id, 0);
    check("t1_gnt", gnt, 8'h01);
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_rst_gnt", gnt, 0);
    check("t1_rst_valid", bus_valid, 0);
    check("t1_rst_data", bus_data, 0);
    check("t1_rst_busy", busy, 0);
    req = 8'h11;
    #2;
    rst_n = 1'b1;
    step(1);
    check("t1_regrant_id", gnt_id, 0);
    check("t1_regrant_gnt", gnt, 8'h01);
    req = 8'h00;
    step(2);

    // Round-robin over all eight, starting from a fresh ptr
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    req = 8'hFF;
    glog.delete();
    dlog.delete();
    vc = 0;
    pb = 1'b0;
    for (int s = 1; s <= 41; s++) begin
      step(1);
      if (s <= 40 && bus_valid) vc++;
      if (busy && !pb) dlog.push_back(int'(gnt_id));
      pb = busy;
    end
    check("t4_beats", vc, 32);
    check("t4_dut_grants", dlog.size(), 9);
    check("t4_model_grants", glog.size(), 9);
    for (int i = 0; i < 9 && i < dlog.size() && i < glog.size(); i++) begin
      check("t4_dut_order", dlog[i], i % 8);
      check("t4_model_order", glog[i], i % 8);
    end
    req = 8'h00;
    step(2);

    // Sole requester: 4 beats, 1 idle, re-grant
    exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    req = 8'h01;
    for (int s = 0; s < 6; s++) begin
      step(1);
      check("t3_valid", bus_valid, exp_v[s]);
    end
    check("t3_regrant", gnt, 8'h01);
    req = 8'h00;
    step(2);

    // Wrap and skip from ptr=6
    req = 8'h20;
    step(1);
    check("t5_g5", gnt_id, 5);
    req = 8'h00;
    step(2);
    req = 8'h21;
    step(1);
    check("t5_wrap0", gnt_id, 0);
    step(5);
    check("t5_next5", gnt_id, 5);
    check("t5_next5_gnt", gnt, 8'h20);
    req = 8'h00;
    step(2);

    // Enable gating
    en = 1'b0;
    req = 8'h10;
    for (int s = 0; s < 3; s++) begin
      step(1);
      check("t6_hold_busy", busy, 0);
      check("t6_hold_gnt", gnt, 0);
    end
    en = 1'b1;
    step(1);
    check("t6_gnt", gnt, 8'h10);
    check("t6_gnt_id", gnt_id, 4);
    en = 1'b0;
    vc = bus_valid ? 1 : 0;
    for (int s = 0; s < 3; s++) begin
      step(1);
      if (bus_valid) vc++;
    end
    check("t6_beats", vc, 4);
    step(1);
    check("t6_released", busy, 0);
    step(2);
    check("t6_stay_idle", busy, 0);
    req = 8'h00;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
